// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and sticky misaligned-branch flag.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               flush,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out,
    output logic               misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              squash;
    logic              load;
    logic              hold;

    // Sequential-fetch address wraps naturally at 2^ADDR_W.
    assign pc_inc    = pc + PC_STEP;
    assign imem_addr = pc;

    // A redirect squashes the wrong-path fetch even while frozen.
    assign squash = flush | branch_taken;
    assign hold   = ~squash & freeze;
    assign load   = ~squash & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_INIT;
        end else if (branch_taken) begin
            pc <= {branch_addr[ADDR_W-1:2], 2'b00};
        end else if (!freeze) begin
            pc <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || squash) begin
            pc_out    <= '0;
            instr_out <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            pc_out    <= pc_inc;
            instr_out <= imem_rdata;
            valid_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (branch_taken && (branch_addr[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load && fetch_cnt != CNT_MAX) begin
                fetch_cnt <= fetch_cnt + CNT_ONE;
            end
            if (hold && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (squash && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a default-width instance plus an 8-bit-address,
// 2-bit-counter instance for wrap and saturation corners.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, freeze, branch_taken, flush;
    logic [31:0] branch_addr, imem_addr, imem_rdata, pc_out, instr_out;
    logic        valid_out, misalign_err;

    // Small instance: ADDR_W=8, INSTR_W=8, RESET_PC=0xF4, CNT_W=2
    logic        rst_s;
    logic [7:0]  imem_addr_s, imem_rdata_s, pc_out_s, instr_out_s;
    logic        valid_out_s, misalign_err_s;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt, flush_cnt;
    logic [1:0]  fetch_cnt_s, stall_cnt_s, flush_cnt_s;
`endif

    // Instruction memory models: word content derived from its address
    assign imem_rdata   = 32'hC0DE_0000 ^ imem_addr;
    assign imem_rdata_s = 8'h5A ^ imem_addr_s;

    fetch_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .flush(flush), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_out(pc_out), .instr_out(instr_out),
        .valid_out(valid_out), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(32'hF4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst_s), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(8'h00), .flush(1'b0), .imem_addr(imem_addr_s),
        .imem_rdata(imem_rdata_s), .pc_out(pc_out_s), .instr_out(instr_out_s),
        .valid_out(valid_out_s), .misalign_err(misalign_err_s)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks the full main-instance output set after an edge
    task automatic check_main(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_valid, input logic e_mis);
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".pc_out"}, pc_out, e_pc);
        check({tag, ".instr_out"}, instr_out, e_instr);
        check({tag, ".valid_out"}, 32'(valid_out), 32'(e_valid));
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'(e_mis));
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_cnt(input string tag, input int f, input int s, input int fl);
        check({tag, ".fetch_cnt"}, 32'(fetch_cnt), f);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), s);
        check({tag, ".flush_cnt"}, 32'(flush_cnt), fl);
    endtask
`endif

    initial begin
        rst = 1'b1; rst_s = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        flush = 1'b0; branch_addr = 32'h0;

        // Reset state
        tick;
        check_main("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_cnt("reset", 0, 0, 0);
`endif

        // Free-running fetch: imem_addr 0,4,8,12 and pc_out 4,8,12
        rst = 1'b0;
        check("run0.imem_addr", imem_addr, 32'h0);
        tick; check_main("run1", 32'h4, 32'h4, mem(32'h0), 1'b1, 1'b0);
        tick; check_main("run2", 32'h8, 32'h8, mem(32'h4), 1'b1, 1'b0);
        tick; check_main("run3", 32'hC, 32'hC, mem(32'h8), 1'b1, 1'b0);

        // Three freeze cycles hold PC and IF/ID
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick; check_main("freeze", 32'hC, 32'hC, mem(32'h8), 1'b1, 1'b0);
        end
`ifdef FETCH_PERF_CNT_EN
        check_cnt("freeze", 3, 3, 0);
`endif
        freeze = 1'b0;
        tick; check_main("unfreeze", 32'h10, 32'h10, mem(32'hC), 1'b1, 1'b0);

        // Branch to 0x40 at PC=0x10: one bubble, then target with pc_out=0x44
        branch_taken = 1'b1; branch_addr = 32'h40;
        tick; check_main("br", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_cnt("br", 4, 3, 1);
`endif
        branch_taken = 1'b0;
        tick; check_main("br_tgt", 32'h44, 32'h44, mem(32'h40), 1'b1, 1'b0);

        // Plain flush squashes IF/ID while PC advances
        flush = 1'b1;
        tick; check_main("flush", 32'h48, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b0;
        tick; check_main("post_flush", 32'h4C, 32'h4C, mem(32'h48), 1'b1, 1'b0);

        // Freeze with flush: squash wins for IF/ID, PC holds
        freeze = 1'b1; flush = 1'b1;
        tick; check_main("frz_flush", 32'h4C, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b0;
        tick; check_main("frz_bubble", 32'h4C, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_cnt("frz_flush", 6, 4, 3);
`endif

        // Misaligned branch during freeze: target aligned down, flag sticky
        branch_taken = 1'b1; branch_addr = 32'h103;
        tick; check_main("mis_br", 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
        branch_taken = 1'b0; freeze = 1'b0;
        tick; check_main("mis_hold1", 32'h104, 32'h104, mem(32'h100), 1'b1, 1'b1);
        tick; check_main("mis_hold2", 32'h108, 32'h108, mem(32'h104), 1'b1, 1'b1);

        // Reset during freeze and branch overrides everything
        freeze = 1'b1;
        tick; check_main("pre_rst", 32'h108, 32'h108, mem(32'h104), 1'b1, 1'b1);
        rst = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
        tick; check_main("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_cnt("rst_mid", 0, 0, 0);
`endif
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        tick; check_main("rst_resume", 32'h4, 32'h4, mem(32'h0), 1'b1, 1'b0);

        // Small instance: PC wraps 0xFC -> 0x00, fetch_cnt saturates at 3
        check("s_reset.imem_addr", 32'(imem_addr_s), 32'hF4);
        check("s_reset.valid_out", 32'(valid_out_s), 32'h0);
        rst_s = 1'b0;
        tick;
        check("s1.imem_addr", 32'(imem_addr_s), 32'hF8);
        check("s1.instr_out", 32'(instr_out_s), 32'hAE);
        tick;
        check("s2.imem_addr", 32'(imem_addr_s), 32'hFC);
        check("s2.pc_out", 32'(pc_out_s), 32'hFC);
        tick;
        check("s3.imem_addr", 32'(imem_addr_s), 32'h00);
        check("s3.pc_out", 32'(pc_out_s), 32'h00);
        check("s3.instr_out", 32'(instr_out_s), 32'hA6);
        check("s3.valid_out", 32'(valid_out_s), 32'h1);
        tick;
        check("s4.imem_addr", 32'(imem_addr_s), 32'h04);
        tick;
        check("s5.pc_out", 32'(pc_out_s), 32'h08);
`ifdef FETCH_PERF_CNT_EN
        check("s5.fetch_cnt", 32'(fetch_cnt_s), 32'h3);
        check("s5.flush_cnt", 32'(flush_cnt_s), 32'h0);
`endif
        check("s5.misalign_err", 32'(misalign_err_s), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
